// File: rtl/demux2x32_stream_pkg.sv
// Shared select encodings and default geometry for the 1-to-2 stream demux.
// The select polarity matches the 2:1 select mux, so both blocks can share one select signal.
package demux_pkg;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/demux2x32_stream_fifo.sv
// Small push/pop FIFO: head data comes straight from registered storage, and a pushed entry is visible after 1 edge.
// The FIFO has no internal backpressure. The caller must not push when full or pop when empty.
module stream_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Storage holds no reset: contents are meaningless until count covers them.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux2x32_stream.sv
// Steers each input beat into FIFO A (I_SEL=1) or FIFO B (I_SEL=0). A beat appears on the output 1 cycle after it is accepted.
// I_READY comes only from the selected FIFO's registered full flag. No combinational path runs from A_READY or B_READY to the input.
module demux2x32_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   CLK,
  input  logic                   CLRN,
  input  logic                   I_VALID,
  output logic                   I_READY,
  input  logic [WIDTH-1:0]       I_DATA,
  input  logic                   I_SEL,
  output logic                   A_VALID,
  input  logic                   A_READY,
  output logic [WIDTH-1:0]       A_DATA,
  output logic [$clog2(DEPTH):0] A_COUNT,
  output logic                   B_VALID,
  input  logic                   B_READY,
  output logic [WIDTH-1:0]       B_DATA,
  output logic [$clog2(DEPTH):0] B_COUNT
);

  logic a_full, a_empty, a_push, a_pop;
  logic b_full, b_empty, b_push, b_pop;
  logic in_fire;

  // A full FIFO only blocks the input when the head beat targets that side.
  assign I_READY = (I_SEL == SEL_A) ? !a_full : !b_full;
  assign in_fire = I_VALID && I_READY;
  assign a_push  = in_fire && (I_SEL == SEL_A);
  assign b_push  = in_fire && (I_SEL == SEL_B);

  assign A_VALID = !a_empty;
  assign B_VALID = !b_empty;
  assign a_pop   = A_VALID && A_READY;
  assign b_pop   = B_VALID && B_READY;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .CLK       (CLK),
    .CLRN      (CLRN),
    .push      (a_push),
    .push_data (I_DATA),
    .pop       (a_pop),
    .full      (a_full),
    .empty     (a_empty),
    .count     (A_COUNT),
    .head_data (A_DATA)
  );

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .CLK       (CLK),
    .CLRN      (CLRN),
    .push      (b_push),
    .push_data (I_DATA),
    .pop       (b_pop),
    .full      (b_full),
    .empty     (b_empty),
    .count     (B_COUNT),
    .head_data (B_DATA)
  );

endmodule

// File: tb/tb_demux2x32_stream.sv
// Directed bench for the 1-to-2 stream demux: every expected value is hand-derived from the stimulus.
module tb_demux2x32_stream;

  logic        CLK = 1'b0;
  logic        CLRN;
  logic        I_VALID;
  logic        I_READY;
  logic [31:0] I_DATA;
  logic        I_SEL;
  logic        A_VALID, A_READY;
  logic [31:0] A_DATA;
  logic [1:0]  A_COUNT;
  logic        B_VALID, B_READY;
  logic [31:0] B_DATA;
  logic [1:0]  B_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  demux2x32_stream #(.WIDTH(32), .DEPTH(2)) dut (
    .CLK     (CLK),
    .CLRN    (CLRN),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .I_DATA  (I_DATA),
    .I_SEL   (I_SEL),
    .A_VALID (A_VALID),
    .A_READY (A_READY),
    .A_DATA  (A_DATA),
    .A_COUNT (A_COUNT),
    .B_VALID (B_VALID),
    .B_READY (B_READY),
    .B_DATA  (B_DATA),
    .B_COUNT (B_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic vld, input logic sel, input logic [31:0] dat);
    I_VALID = vld;
    I_SEL   = sel;
    I_DATA  = dat;
    #1;
  endtask

  initial begin
    int  idx_in;
    int  idx_out;
    bit  in_fire;
    bit  out_fire;
    logic [31:0] out_dat;

    CLRN = 1'b0; I_VALID = 1'b0; I_DATA = '0; I_SEL = 1'b0;
    A_READY = 1'b0; B_READY = 1'b0;
    repeat (3) tick();
    CLRN = 1'b1;
    tick();

    // Reset then idle
    check("rst_i_ready", I_READY, 1);
    check("rst_a_valid", A_VALID, 0);
    check("rst_b_valid", B_VALID, 0);
    check("rst_a_count", A_COUNT, 0);
    check("rst_b_count", B_COUNT, 0);

    // Alternating steering
    A_READY = 1'b1; B_READY = 1'b1;
    drive(1, 1, 32'h11); tick();
    check("alt_a_vld0", A_VALID, 1);
    check("alt_a_dat0", A_DATA, 32'h11);
    check("alt_b_vld0", B_VALID, 0);
    drive(1, 0, 32'h22); tick();
    check("alt_b_vld1", B_VALID, 1);
    check("alt_b_dat1", B_DATA, 32'h22);
    check("alt_a_vld1", A_VALID, 0);
    drive(1, 1, 32'h33); tick();
    check("alt_a_vld2", A_VALID, 1);
    check("alt_a_dat2", A_DATA, 32'h33);
    check("alt_b_vld2", B_VALID, 0);
    drive(0, 0, 32'h0); tick();
    check("alt_a_idle", A_VALID, 0);

    // Fill A and block
    A_READY = 1'b0;
    drive(1, 1, 32'hA0); tick();
    drive(1, 1, 32'hA1); tick();
    check("fill_a_count", A_COUNT, 2);
    check("fill_a_head", A_DATA, 32'hA0);
    drive(1, 1, 32'hA2);
    check("fill_i_ready_lo", I_READY, 0);
    tick();
    check("fill_a_count_hold", A_COUNT, 2);
    drive(1, 0, 32'hB0);
    check("fill_i_ready_b", I_READY, 1);
    tick();
    check("fill_b_vld", B_VALID, 1);
    check("fill_b_dat", B_DATA, 32'hB0);

    // Head-of-line: A full, sel1 beat held while B drains
    drive(1, 1, 32'hA2);
    check("hol_i_ready_lo", I_READY, 0);
    tick();
    check("hol_b_drained", B_VALID, 0);
    check("hol_i_ready_lo2", I_READY, 0);
    check("hol_a_count", A_COUNT, 2);
    A_READY = 1'b1;
    tick();
    A_READY = 1'b0;
    check("hol_a_pop_count", A_COUNT, 1);
    check("hol_a_head_a1", A_DATA, 32'hA1);
    #1;
    check("hol_i_ready_hi", I_READY, 1);
    tick();
    check("hol_a2_count", A_COUNT, 2);
    check("hol_a2_head", A_DATA, 32'hA1);

    // Drain to count 1 (head A2), then push and pop in the same cycle
    drive(0, 1, 32'h0);
    A_READY = 1'b1;
    tick();
    check("pp_pre_count", A_COUNT, 1);
    check("pp_pre_head", A_DATA, 32'hA2);
    drive(1, 1, 32'h55); tick();
    check("pp_count", A_COUNT, 1);
    check("pp_head", A_DATA, 32'h55);
    drive(0, 1, 32'h0); tick();
    check("pp_empty", A_COUNT, 0);

    // Reset pulse with A holding two beats
    A_READY = 1'b0;
    drive(1, 1, 32'hC0); tick();
    drive(1, 1, 32'hC1); tick();
    drive(0, 1, 32'h0);
    check("mid_pre_count", A_COUNT, 2);
    CLRN = 1'b0;
    #1;
    check("mid_rst_count", A_COUNT, 0);
    check("mid_rst_valid", A_VALID, 0);
    tick();
    CLRN = 1'b1;
    tick();
    check("mid_post_count", A_COUNT, 0);

    // Wrap-around on B with B_READY toggling every cycle
    idx_in  = 0;
    idx_out = 0;
    for (int cyc = 0; cyc < 80 && idx_out < 10; cyc++) begin
      B_READY = cyc[0];
      drive(idx_in < 10, 0, 32'(idx_in));
      in_fire  = I_VALID && I_READY;
      out_fire = B_VALID && B_READY;
      out_dat  = B_DATA;
      tick();
      if (out_fire) begin
        check("wrap_b_dat", out_dat, 32'(idx_out));
        idx_out++;
      end
      if (in_fire) idx_in++;
      check("wrap_b_count_le2", {31'b0, (B_COUNT <= 2'd2)}, 1);
    end
    check("wrap_all_out", idx_out, 10);
    check("wrap_all_in", idx_in, 10);
    drive(0, 0, 32'h0);
    tick();
    check("wrap_b_empty", B_VALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
